// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter_if
//  Description : Bundle of requester, response and shared-ALU signals for the
//                two-requester ALU share arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int W   = 4,
  parameter int OPW = 2
);
  // requester side
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [OPW-1:0] req_opcode0;
  logic [OPW-1:0] req_opcode1;
  logic [W-1:0]   req_a0;
  logic [W-1:0]   req_a1;
  logic [W-1:0]   req_b0;
  logic [W-1:0]   req_b1;
  // response side
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [W-1:0]   resp_data0;
  logic [W-1:0]   resp_data1;
  // shared ALU
  logic [OPW-1:0] alu_opcode;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_out;
  // status
  logic           busy;
  logic [7:0]     op_count;

  // environment: requesters, consumers and the ALU itself
  modport master (
    output req_valid, req_opcode0, req_opcode1, req_a0, req_a1, req_b0, req_b1,
    output resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data0, resp_data1,
    input  alu_opcode, alu_a, alu_b, busy, op_count
  );

  // the arbiter
  modport slave (
    input  req_valid, req_opcode0, req_opcode1, req_a0, req_a1, req_b0, req_b1,
    input  resp_ready, alu_out,
    output req_ready, resp_valid, resp_data0, resp_data1,
    output alu_opcode, alu_a, alu_b, busy, op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one combinational ALU between two requesters. A
//                request is granted in IDLE (round-robin on ties), executed
//                for one cycle in EXEC, and its result is parked in a
//                per-requester response register until consumed.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int W   = 4,
  parameter int OPW = 2
) (
  input wire logic         clk,
  input wire logic         rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic           r_last_grant;   // requester granted most recently
  logic           r_owner;        // requester whose operation is in flight
  logic [OPW-1:0] r_opcode;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [1:0]     r_resp_valid;
  logic [W-1:0]   r_resp_data0;
  logic [W-1:0]   r_resp_data1;
  logic [7:0]     r_op_count;

  logic [1:0]     w_eligible;
  logic [1:0]     w_grant;
  logic           w_accept;
  logic           w_accept_idx;
  logic           w_complete;

  // Grant selection and next state; a held response (even while it is being
  // drained) keeps its requester out of arbitration, and nothing is granted
  // while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    w_eligible   = bus.req_valid & ~r_resp_valid;
    w_grant      = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (!rst) begin
          if (w_eligible == 2'b11) begin
            w_grant = r_last_grant ? 2'b01 : 2'b10;
          end else begin
            w_grant = w_eligible;
          end
        end
        if (w_grant != 2'b00) begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_accept     = |w_grant;
    w_accept_idx = w_grant[1];
    w_complete   = (r_state == S_EXEC);
  end

  assign bus.req_ready  = w_grant;
  assign bus.busy       = (r_state == S_EXEC);
  assign bus.alu_opcode = r_opcode;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data0 = r_resp_data0;
  assign bus.resp_data1 = r_resp_data1;
  assign bus.op_count   = r_op_count;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture on handshake; the registers keep driving the ALU when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_opcode     <= w_accept_idx ? bus.req_opcode1 : bus.req_opcode0;
      r_a          <= w_accept_idx ? bus.req_a1      : bus.req_a0;
      r_b          <= w_accept_idx ? bus.req_b1      : bus.req_b0;
      r_owner      <= w_accept_idx;
      r_last_grant <= w_accept_idx;
    end
  end

  // Response registers: drained by resp_ready, filled at the end of EXEC.
  // The owner's response is always empty during EXEC, so fill and drain
  // never target the same requester in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 2'b00;
      r_resp_data0 <= '0;
      r_resp_data1 <= '0;
    end else begin
      if (r_resp_valid[0] && bus.resp_ready[0]) begin
        r_resp_valid[0] <= 1'b0;
      end
      if (r_resp_valid[1] && bus.resp_ready[1]) begin
        r_resp_valid[1] <= 1'b0;
      end
      if (w_complete && (r_owner == 1'b0)) begin
        r_resp_valid[0] <= 1'b1;
        r_resp_data0    <= bus.alu_out;
      end
      if (w_complete && (r_owner == 1'b1)) begin
        r_resp_valid[1] <= 1'b1;
        r_resp_data1    <= bus.alu_out;
      end
    end
  end

  // Completed-operation counter, wraps modulo 256
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= 8'd0;
    end else if (w_complete) begin
      r_op_count <= r_op_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 4, the operand and result width matching the shared SimpleALU datapath.
REQ-002 The block SHALL have parameter OPW, default 2, the ALU opcode width.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester (bit i = requester i) operation request.
REQ-006 req_ready  output  2  per-requester request acceptance.
REQ-007 req_opcode0/req_opcode1  input  OPW each  requested opcode.
REQ-008 req_a0/req_a1, req_b0/req_b1  input  W each  requested operands.
REQ-009 resp_valid  output  2  per-requester result available.
REQ-010 resp_ready  input  2  per-requester result consumed.
REQ-011 resp_data0/resp_data1  output  W each  result for requester i.
REQ-012 alu_opcode  output  OPW; alu_a, alu_b  output  W: drive the shared ALU.
REQ-013 alu_out  input  W  combinational ALU result.
REQ-014 busy  output  1  high while in EXEC.
REQ-015 op_count  output  8  completed-operation counter.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE, EXEC.
REQ-017 Requester i SHALL be eligible in IDLE when req_valid[i]=1 and resp_valid[i]=0; a requester whose response is held (including the cycle it is drained) is not eligible.
REQ-018 Grant: one eligible -> that one; both eligible -> the requester not granted last (round-robin pointer last_grant).
REQ-019 req_ready[i] SHALL be 1 only in IDLE and only for the granted requester (combinational from state, req_valid, resp_valid, last_grant); at most one bit set.
REQ-020 On handshake (req_valid[i] & req_ready[i]) the opcode, a, b of requester i SHALL be latched into operand registers, owner<=i, last_grant<=i, state<=EXEC.
REQ-021 alu_opcode/alu_a/alu_b SHALL be driven directly from the operand registers at all times (hold last operation when idle).
REQ-022 In EXEC, at the rising edge ending the cycle, alu_out SHALL be captured into resp_data[owner], resp_valid[owner]<=1, op_count<=op_count+1 (mod 256 wrap), state<=IDLE.
REQ-023 Latency: handshake in cycle N -> resp_valid high from cycle N+2; maximum throughput one operation per 2 cycles.
REQ-024 resp_valid[i] SHALL stay 1 and resp_data[i] stable until a cycle with resp_ready[i]=1, after which resp_valid[i]<=0; resp_ready with resp_valid=0 has no effect.
REQ-025 Responses of the two requesters SHALL be independent; one stalled consumer SHALL NOT block the other requester.
REQ-026 busy SHALL equal (state==EXEC); no request is accepted while busy.
REQ-027 Requesters hold req_valid and operands stable until accepted; the block does not check this and SHALL NOT buffer unaccepted requests.

Reset
REQ-028 On reset assertion, immediately and independent of clock: state=IDLE, resp_valid=0, resp_data0/1=0, operand registers=0 (alu_opcode, alu_a, alu_b = 0), op_count=0, last_grant=1 (requester 0 wins first tie), busy=0.
REQ-029 Reset during EXEC SHALL discard the in-flight operation; no response and no count increment is produced.
REQ-030 req_ready SHALL be 0 while reset is high.

Verification (ALU model: op0 a+b, op1 a-b, op2 a, op3 b, all mod 16)
REQ-031 Single op: req0 op0 a=3 b=4 accepted cycle N, resp_ready0=1 -> resp_valid0 at N+2, resp_data0=7, op_count=1, busy high only cycle N+1.
REQ-032 Tie and fairness: both valid continuously from reset, responses always accepted -> grant order 0,1,0,1; req1 op1 a=2 b=5 -> resp_data1=13 (wrap).
REQ-033 Back-pressure: req0 result held with resp_ready0=0 for 5 cycles while req0 and req1 valid -> req_ready0 stays 0, req1 served, resp_data0 stable; after resp_ready0 pulse req0 accepted next IDLE.
REQ-034 Counter wrap: 256 completed ops -> op_count returns to 0, 257th -> 1.
REQ-035 Reset mid-op: assert reset in EXEC cycle of req1 op2 a=9 -> resp_valid=0, op_count unchanged at 0, alu_a=0; after release req0 wins first tie.
REQ-036 Eligibility: resp_valid1=1 undrained, only req1 valid -> req_ready=00, busy=0 indefinitely.
